// File: rtl/sqx_mult_pipe.sv
// Pipelined signed fixed-point multiplier producing a*a, b*b, a*b with seed sideband.
// Optional MULT_ROUND_EN: round half up before the FRAC shift instead of truncating.
module sqx_mult_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             ld,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a0_in,
  input  logic [WIDTH-1:0] b0_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] aa_out,
  output logic [WIDTH-1:0] bb_out,
  output logic [WIDTH-1:0] ab_out,
  output logic [WIDTH-1:0] a0_out,
  output logic [WIDTH-1:0] b0_out,
  output logic [2:0]       ovf
);

  localparam int unsigned PW = 2 * WIDTH;

`ifdef MULT_ROUND_EN
  localparam logic [PW-1:0] RND = (PW'(1) << FRAC) >> 1;
`endif

  typedef struct packed {
    logic [2:0]       ovf;
    logic [WIDTH-1:0] aa;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
  } bundle_t;

  // Returns {overflow, low WIDTH bits of (x*y)>>>FRAC}.
  function automatic logic [WIDTH:0] scale(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] s;
    p = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{y[WIDTH-1]}}, y});
`ifdef MULT_ROUND_EN
    p = p + $signed(RND);
`endif
    s = p >>> FRAC;
    return {(|s[PW-1:WIDTH-1]) & ~(&s[PW-1:WIDTH-1]), s[WIDTH-1:0]};
  endfunction

  logic [WIDTH:0]    r_aa;
  logic [WIDTH:0]    r_bb;
  logic [WIDTH:0]    r_ab;
  bundle_t           in_b;
  bundle_t           pipe [STAGES];
  logic [STAGES-1:0] vld;
  logic              adv;

  always_comb begin
    r_aa      = scale(a, a);
    r_bb      = scale(b, b);
    r_ab      = scale(a, b);
    in_b      = '0;
    in_b.ovf  = {r_ab[WIDTH], r_bb[WIDTH], r_aa[WIDTH]};
    in_b.aa   = r_aa[WIDTH-1:0];
    in_b.bb   = r_bb[WIDTH-1:0];
    in_b.ab   = r_ab[WIDTH-1:0];
    in_b.a0   = a0_in;
    in_b.b0   = b0_in;
  end

  assign adv     = ~vld[STAGES-1] | m_ready;
  assign s_ready = aresetn & ~ld & adv;

  // Lock-step shift register; data only loads behind a valid bit so outputs stay 0 until the first bundle.
  always_ff @(posedge aclk) begin
    if (!aresetn || ld) begin
      vld <= '0;
      for (int unsigned i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else if (adv) begin
      vld[0] <= s_valid;
      if (s_valid) pipe[0] <= in_b;
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) pipe[i] <= pipe[i-1];
      end
    end
  end

  assign m_valid = vld[STAGES-1];
  assign aa_out  = pipe[STAGES-1].aa;
  assign bb_out  = pipe[STAGES-1].bb;
  assign ab_out  = pipe[STAGES-1].ab;
  assign a0_out  = pipe[STAGES-1].a0;
  assign b0_out  = pipe[STAGES-1].b0;
  assign ovf     = pipe[STAGES-1].ovf;

endmodule
